// File: rtl/safe_mux_pkg.sv
// Shared types and constants for the safe_mux_arbiter slice.
package safe_mux_pkg;

    localparam int DW = 8;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_A,
        GRANT_B,
        FAULT
    } state_t;

    // True when a control bit is anything other than a clean 0 or 1.
    // Case equality makes this simulation-only; synthesis sees a constant 0.
    function automatic logic is_unknown(input logic v);
        return (v !== 1'b0) && (v !== 1'b1);
    endfunction

endpackage

// File: rtl/safe_mux2.sv
// X-safe 2:1 mux: an unknown select yields zero data and raises sel_unknown
// instead of propagating X into the datapath.
module safe_mux2
    import safe_mux_pkg::*;
#(
    parameter int W = DW
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         sel_unknown
);

    // Steer a or b; fall back to zero when the select is not a clean 0/1.
    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        y           = '0;
        sel_unknown = is_unknown(sel);
        if (!sel_unknown) begin
            y = sel ? b : a;
        end
    end

endmodule

// File: rtl/safe_mux_arbiter.sv
// Two-source round-robin arbiter with hold limit, one-entry output register
// and a sticky fault state entered on unknown control inputs.
module safe_mux_arbiter
    import safe_mux_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    input  logic          out_ready,
    output logic          sel_unknown,
    input  logic          err_clr
);

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    state_t        state;
    logic [3:0]    hold_cnt;
    logic          last;

    logic          mux_sel;
    logic [DW-1:0] mux_y;
    logic          mux_sel_unknown;

    logic          fault_det;
    logic          can_load;
    logic          xfer;
    logic [3:0]    hold_next;
    logic          hold_done;

    // Select follows the grant; every non-B state parks on a clean 0.
    assign mux_sel = (state == GRANT_B) ? SRC_B : SRC_A;

    safe_mux2 #(.W(DW)) u_mux (
        .sel         (mux_sel),
        .a           (a_data),
        .b           (b_data),
        .y           (mux_y),
        .sel_unknown (mux_sel_unknown)
    );

    assign fault_det = is_unknown(a_valid) | is_unknown(b_valid)
                     | is_unknown(out_ready) | mux_sel_unknown;

    assign can_load = !out_valid || out_ready;

    // Detection gates the readies in the same cycle so no handshake
    // completes while a control input is unknown.
    assign a_ready = (state == GRANT_A) && a_valid && can_load && !fault_det;
    assign b_ready = (state == GRANT_B) && b_valid && can_load && !fault_det;
    assign xfer    = a_ready || b_ready;

    // Count including the current transfer; saturate rather than wrap when
    // the other side is idle and the owner keeps streaming.
    assign hold_next = (xfer && hold_cnt != 4'hF) ? hold_cnt + 4'd1 : hold_cnt;
    assign hold_done = hold_next >= HOLD_LIMIT;

    // Grant FSM, hold counter, round-robin pointer and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // right-hand side sees pre-edge values regardless of statement order.
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            last        <= SRC_B;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_src     <= SRC_A;
            sel_unknown <= 1'b0;
        end else if (fault_det) begin
            state       <= FAULT;
            sel_unknown <= 1'b1;
            hold_cnt    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= mux_y;
                out_src   <= mux_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (a_valid && (!b_valid || last == SRC_B)) begin
                        state <= GRANT_A;
                        last  <= SRC_A;
                    end else if (b_valid) begin
                        state <= GRANT_B;
                        last  <= SRC_B;
                    end
                end

                GRANT_A: begin
                    if (!a_valid || (hold_done && b_valid)) begin
                        hold_cnt <= '0;
                        if (b_valid) begin
                            state <= GRANT_B;
                            last  <= SRC_B;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_next;
                    end
                end

                GRANT_B: begin
                    if (!b_valid || (hold_done && a_valid)) begin
                        hold_cnt <= '0;
                        if (a_valid) begin
                            state <= GRANT_A;
                            last  <= SRC_A;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_next;
                    end
                end

                FAULT: begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    if (err_clr) begin
                        state       <= IDLE;
                        sel_unknown <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_safe_mux_arbiter.sv
// Directed bench for safe_mux_arbiter: expected output beats are queued as
// stimulus is driven and popped by a monitor whenever the sink consumes one.
module tb_safe_mux_arbiter;

    typedef struct {
        logic [7:0] data;
        logic       src;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src;
    logic       out_ready;
    logic       sel_unknown;
    logic       err_clr;

    int   tests_run;
    int   tests_failed;
    exp_t exp_q[$];
    exp_t mon_e;
    logic probe;
    logic x_capable;
    logic bsel;

    safe_mux_arbiter #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_ready   (out_ready),
        .sel_unknown (sel_unknown),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change just after the rising edge; outputs are read on the falling edge.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every beat the sink takes must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("sb_data", 32'(out_data), 32'(mon_e.data));
                check("sb_src", 32'(out_src), 32'(mon_e.src));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        a_valid      = 1'b0;
        a_data       = 8'h00;
        b_valid      = 1'b0;
        b_data       = 8'h00;
        out_ready    = 1'b1;
        err_clr      = 1'b0;

        // Only a four-state simulator can carry an X on a control input.
        probe     = 1'bx;
        x_capable = (probe !== 1'b0) && (probe !== 1'b1);

        // Reset state
        to_sample();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        check("rst_sel_unknown", 32'(sel_unknown), 32'd0);
        to_drive();
        rst_n = 1'b1;

        // Single A request: grant one cycle later, data one cycle after that
        to_drive();
        a_valid = 1'b1;
        a_data  = 8'h11;
        to_sample();
        check("t1_idle_a_ready", 32'(a_ready), 32'd0);
        to_drive();
        exp_q.push_back('{8'h11, 1'b0});
        to_sample();
        check("t1_grant_a_ready", 32'(a_ready), 32'd1);
        to_drive();
        a_valid = 1'b0;
        to_sample();
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", 32'(out_data), 32'h11);
        check("t1_out_src", 32'(out_src), 32'd0);
        to_drive();
        to_sample();
        check("t1_drained", 32'(out_valid), 32'd0);
        to_drive();

        // Both sources streaming; A took the last grant so B wins the tie.
        // Expect BBBB AAAA BBBB with a handshake every cycle.
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'hAA;
        b_data  = 8'hBB;
        to_sample();
        check("t2_idle_readies", 32'({a_ready, b_ready}), 32'd0);
        to_drive();
        for (int k = 0; k < 12; k++) begin
            bsel = ((k / 4) % 2) == 0;
            exp_q.push_back('{bsel ? 8'hBB : 8'hAA, bsel});
            to_sample();
            check("t2_a_ready", 32'(a_ready), 32'(!bsel));
            check("t2_b_ready", 32'(b_ready), 32'(bsel));
            to_drive();
        end

        // Sink stall: readies drop, output holds, hold count frozen
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            to_sample();
            check("t3_stall_readies", 32'({a_ready, b_ready}), 32'd0);
            check("t3_stall_valid", 32'(out_valid), 32'd1);
            check("t3_stall_data", 32'(out_data), 32'hBB);
            to_drive();
        end
        out_ready = 1'b1;
        // A still owes its full run of four before B gets the channel back
        for (int k = 0; k < 5; k++) begin
            bsel = (k == 4);
            exp_q.push_back('{bsel ? 8'hBB : 8'hAA, bsel});
            to_sample();
            check("t3_resume_a_ready", 32'(a_ready), 32'(!bsel));
            check("t3_resume_b_ready", 32'(b_ready), 32'(bsel));
            to_drive();
        end

        // Unknown control during GRANT_B
        if (x_capable) begin
            a_valid = 1'bx;
            to_sample();
            check("t4_x_b_ready", 32'(b_ready), 32'd0);
            to_drive();
            a_valid = 1'b0;
            b_valid = 1'b0;
            err_clr = 1'b1;
            to_sample();
            check("t4_fault_flag", 32'(sel_unknown), 32'd1);
            check("t4_fault_valid", 32'(out_valid), 32'd0);
            check("t4_fault_data", 32'(out_data), 32'h00);
            check("t4_fault_readies", 32'({a_ready, b_ready}), 32'd0);
            to_drive();
            err_clr = 1'b0;
            to_sample();
            check("t4_cleared_flag", 32'(sel_unknown), 32'd0);
            to_drive();
        end else begin
            a_valid = 1'b0;
            b_valid = 1'b0;
            to_sample();
            to_drive();
        end

        // err_clr outside FAULT has no effect
        err_clr = 1'b1;
        to_sample();
        check("t4_idle_err_clr_flag", 32'(sel_unknown), 32'd0);
        check("t4_idle_err_clr_valid", 32'(out_valid), 32'd0);
        to_drive();
        err_clr = 1'b0;

        // Reset mid-stream with a beat held in the output register
        a_valid = 1'b1;
        a_data  = 8'h5C;
        to_drive();
        to_sample();
        check("t5_a_ready", 32'(a_ready), 32'd1);
        to_drive();
        a_valid   = 1'b0;
        out_ready = 1'b0;
        to_sample();
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_data", 32'(out_data), 32'h5C);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'h00);
        check("t5_rst_src", 32'(out_src), 32'd0);
        check("t5_rst_readies", 32'({a_ready, b_ready}), 32'd0);
        check("t5_rst_flag", 32'(sel_unknown), 32'd0);
        to_drive();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        a_data    = 8'h21;
        b_data    = 8'h42;
        to_sample();
        check("t5_idle_readies", 32'({a_ready, b_ready}), 32'd0);
        to_drive();
        exp_q.push_back('{8'h21, 1'b0});
        to_sample();
        check("t5_tie_a_ready", 32'(a_ready), 32'd1);
        check("t5_tie_b_ready", 32'(b_ready), 32'd0);
        to_drive();
        a_valid = 1'b0;
        b_valid = 1'b0;
        to_sample();
        to_drive();
        to_sample();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/safe_mux_arbiter.md
# safe_mux_arbiter

Two-requester round-robin arbiter that shares one 8-bit output channel between sources A and B. Each source has a valid/ready handshake. The arbiter steers data through the team's safe 2:1 mux and registers the result into a one-entry output stage. It sits upstream of any single-consumer sink. Any unknown value on a control input forces a sticky fault state: the output is zeroed and all traffic stops until software clears it.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive accepted transfers per grant while the other source is requesting. Range 1..15.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `a_valid`  in  1  source A has data
- `a_data`  in  8  source A payload
- `a_ready`  out  1  A transfer accepted this cycle
- `b_valid`  in  1  source B has data
- `b_data`  in  8  source B payload
- `b_ready`  out  1  B transfer accepted this cycle
- `out_valid`  out  1  output register holds data
- `out_data`  out  8  output payload
- `out_src`  out  1  source of `out_data` (0=A, 1=B)
- `out_ready`  in  1  sink accepts output
- `sel_unknown`  out  1  sticky fault flag
- `err_clr`  in  1  clears fault; valid only in FAULT

## Operation
- States:
  - IDLE: no grant.
  - GRANT_A: A owns the mux.
  - GRANT_B: B owns the mux.
  - FAULT: unknown control input seen.
- Mux select: 0 in GRANT_A, 1 in GRANT_B, X-free 0 otherwise.
- `can_load = !out_valid || out_ready`.
- Ready outputs:
  - `a_ready = (state==GRANT_A) && a_valid && can_load`.
  - `b_ready` is symmetric for GRANT_B.
  - Both readies are 0 in IDLE and FAULT.
- A transfer loads `out_data`/`out_src`, sets `out_valid`, and increments `hold_cnt`.
- `out_valid` clears when `out_ready` is high and no new load occurs.
- Round-robin pointer `last` records the last granted source. It resets to B, so A wins the first tie.
- IDLE transitions:
  - Only A valid → GRANT_A.
  - Only B valid → GRANT_B.
  - Both valid → the source not equal to `last`.
  - Neither valid → stay in IDLE.
- GRANT_X transitions, evaluated every cycle:
  - Switch when own valid is low, or when `hold_cnt` reaches `MAX_HOLD` (counting the current transfer) and the other source is valid.
  - On switch, go to GRANT_other if the other source is valid, else to IDLE.
  - A direct GRANT_A↔GRANT_B switch inserts no idle cycle.
- On any grant change, `hold_cnt` resets to 0 and `last` updates to the new owner.
- If `out_valid` is stalled, the grant is still kept or switched per the rules above. No transfer occurs, and `hold_cnt` is unchanged.
- Fault detection:
  - Trigger: `a_valid`, `b_valid`, or `out_ready` is not exactly 0 or 1 (case-equality check).
  - This is simulation-only; synthesis never enters FAULT through this path.
  - On trigger, the next state is FAULT from any state, and `sel_unknown` sets.
- FAULT behaviour:
  - `out_valid` is forced to 0, `out_data` to 0x00, and both readies to 0.
  - Stays in FAULT until `err_clr`=1 with all controls known. It then goes to IDLE and clears `sel_unknown`.
  - `err_clr` outside FAULT is ignored.

## Timing
- Reset values: state=IDLE, `out_valid`=0, `out_data`=0x00, `out_src`=0, `a_ready`=0, `b_ready`=0, `sel_unknown`=0, `hold_cnt`=0, `last`=B.
- Asserting reset mid-transfer discards the output register contents immediately (asynchronous reset).
- Readies are combinational from state, the valid inputs and `can_load`. There is no combinational path from data to any control signal.
- Request latency:
  - First grant comes 1 cycle after valid rises from IDLE.
  - Data appears on `out_data` 1 cycle after the handshake.
- Back-to-back throughput is one beat per cycle while `out_ready`=1.
- FAULT is entered on the edge after detection.
  - The entry edge itself forces `out_valid`=0.
  - The ready outputs are 0 in that same cycle only if the ready logic is gated by the detection condition combinationally. Implement it that way so no handshake completes on an unknown cycle.

## Structure
- Package `safe_mux_pkg` holds:
  - the state enum {IDLE, GRANT_A, GRANT_B, FAULT};
  - the source encoding constants SRC_A=0 and SRC_B=1;
  - the data width constant DW=8.
- Sub-module: data steering instantiates `safe_mux2`, with `sel` driven from the grant state. Its `sel_unknown` output is OR-ed into the fault detect.
- The FSM, hold counter and output register live in this module.

## Test plan
- Reset, then `a_valid`=1 with `a_data`=0x11 → GRANT_A next cycle, `a_ready`=1, `out_data`=0x11 with `out_src`=0 one cycle later.
- Both sources valid continuously (A=0xAA, B=0xBB), `out_ready`=1, `MAX_HOLD`=4 → output pattern is AAAA BBBB AAAA…, with no idle cycle at the switches.
- `out_ready`=0 for 3 cycles with `out_valid`=1 → readies stay 0, `out_data` is stable, `hold_cnt` is unchanged. Flow resumes on the first `out_ready`=1.
- During GRANT_B, drive `a_valid`=1'bx → next cycle FAULT: `sel_unknown`=1, `out_valid`=0, `out_data`=0x00. Pulsing `err_clr` with clean inputs → IDLE and `sel_unknown`=0.
- Assert `rst_n`=0 mid-stream with `out_valid`=1 → all outputs immediately take their reset values. After release, A wins a tie.
